// File: rtl/template_matcher.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : template_matcher
// Description : Scores a stream of 16x16 candidate windows against a stored
//               16x16 template by sum of absolute differences, tracks the
//               minimum-SAD position over one 65x65 scan and reports it once
//               the frame's last window has drained through the pipeline.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module template_matcher (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0][15:0][7:0] template_data,
   input  logic                   template_load,
   input  logic [15:0][15:0][7:0] window_data,
   input  logic                   window_ready,
   input  logic                   frame_done,
   output logic                   receive,
   output logic                   busy,
   output logic [15:0]            best_sad,
   output logic [6:0]             best_row,
   output logic [6:0]             best_col,
   output logic                   result_valid
);

   localparam logic [6:0]  C_LAST_POS = 7'd64;
   localparam logic [15:0] C_SAD_INIT = 16'hFFFF;

   // Stored template and scan position
   logic [15:0][15:0][7:0] r_tmpl;
   logic [6:0]             r_cur_row;
   logic [6:0]             r_cur_col;
   logic                   r_in_frame;

   // Stage 1: absolute differences
   logic                   r_s1_vld;
   logic                   r_s1_first;
   logic                   r_s1_last;
   logic [6:0]             r_s1_row;
   logic [6:0]             r_s1_col;
   logic [15:0][15:0][7:0] r_s1_diff;

   // Stage 2: per-row sums
   logic                   r_s2_vld;
   logic                   r_s2_first;
   logic                   r_s2_last;
   logic [6:0]             r_s2_row;
   logic [6:0]             r_s2_col;
   logic [15:0][11:0]      r_s2_sum;

   // Stage 3: window SAD
   logic                   r_s3_vld;
   logic                   r_s3_first;
   logic                   r_s3_last;
   logic [6:0]             r_s3_row;
   logic [6:0]             r_s3_col;
   logic [15:0]            r_s3_sad;

   // Running minimum of the frame in progress
   logic [15:0]            r_run_min;
   logic [6:0]             r_run_row;
   logic [6:0]             r_run_col;

   // Published result of the last completed frame
   logic [15:0]            r_best_sad;
   logic [6:0]             r_best_row;
   logic [6:0]             r_best_col;
   logic                   r_result_valid;

   // Combinational datapath
   logic [15:0][15:0][7:0] w_diff;
   logic [15:0][11:0]      w_row_sum;
   logic [15:0]            w_sad;
   logic                   w_first;
   logic                   w_take;
   logic [15:0]            w_new_min;
   logic [6:0]             w_new_row;
   logic [6:0]             w_new_col;

   // No backpressure: every valid window is taken in the cycle it appears.
   assign receive = window_ready;

   // A window arriving while no frame is open starts a new frame.
   assign w_first = ~r_in_frame;

   // Busy covers the open frame, every pipeline stage and the result cycle.
   assign busy = r_in_frame | r_s1_vld | r_s2_vld | r_s3_vld | r_result_valid;

   assign best_sad     = r_best_sad;
   assign best_row     = r_best_row;
   assign best_col     = r_best_col;
   assign result_valid = r_result_valid;

   // Capture the template only while idle so a frame always uses one template.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmpl <= '0;
      end else if (template_load && !busy) begin
         r_tmpl <= template_data;
      end
   end

   // Scan position counters and frame-open tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_row  <= '0;
         r_cur_col  <= '0;
         r_in_frame <= 1'b0;
      end else if (window_ready) begin
         r_in_frame <= ~frame_done;
         if (frame_done) begin
            r_cur_row <= '0;
            r_cur_col <= '0;
         end else if (r_cur_col == C_LAST_POS) begin
            r_cur_col <= '0;
            r_cur_row <= (r_cur_row == C_LAST_POS) ? 7'd0 : r_cur_row + 7'd1;
         end else begin
            r_cur_col <= r_cur_col + 7'd1;
         end
      end
   end

   // Pixel-wise absolute difference between window and template.
   always_comb begin
      w_diff = '0;
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            if (window_data[r][c] >= r_tmpl[r][c]) begin
               w_diff[r][c] = window_data[r][c] - r_tmpl[r][c];
            end else begin
               w_diff[r][c] = r_tmpl[r][c] - window_data[r][c];
            end
         end
      end
   end

   // Stage 1 register: differences plus position tag and frame flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld   <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_row   <= '0;
         r_s1_col   <= '0;
         r_s1_diff  <= '0;
      end else begin
         r_s1_vld <= window_ready;
         if (window_ready) begin
            r_s1_first <= w_first;
            r_s1_last  <= frame_done;
            r_s1_row   <= r_cur_row;
            r_s1_col   <= r_cur_col;
            r_s1_diff  <= w_diff;
         end
      end
   end

   // Sixteen row sums of the stage 1 differences (max 16*255 = 4080).
   always_comb begin
      w_row_sum = '0;
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            w_row_sum[r] = w_row_sum[r] + {4'd0, r_s1_diff[r][c]};
         end
      end
   end

   // Stage 2 register: row sums.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld   <= 1'b0;
         r_s2_first <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s2_row   <= '0;
         r_s2_col   <= '0;
         r_s2_sum   <= '0;
      end else begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_row   <= r_s1_row;
            r_s2_col   <= r_s1_col;
            r_s2_sum   <= w_row_sum;
         end
      end
   end

   // Total SAD of the window (max 65280, fits 16 bits without saturation).
   always_comb begin
      w_sad = '0;
      for (int r = 0; r < 16; r++) begin
         w_sad = w_sad + {4'd0, r_s2_sum[r]};
      end
   end

   // Stage 3 register: window SAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s3_vld   <= 1'b0;
         r_s3_first <= 1'b0;
         r_s3_last  <= 1'b0;
         r_s3_row   <= '0;
         r_s3_col   <= '0;
         r_s3_sad   <= '0;
      end else begin
         r_s3_vld <= r_s2_vld;
         if (r_s2_vld) begin
            r_s3_first <= r_s2_first;
            r_s3_last  <= r_s2_last;
            r_s3_row   <= r_s2_row;
            r_s3_col   <= r_s2_col;
            r_s3_sad   <= w_sad;
         end
      end
   end

   // Strict less-than keeps the earliest scan position on ties; the first
   // window of a frame always replaces the previous frame's minimum.
   always_comb begin
      w_take    = r_s3_first | (r_s3_sad < r_run_min);
      w_new_min = r_run_min;
      w_new_row = r_run_row;
      w_new_col = r_run_col;
      if (w_take) begin
         w_new_min = r_s3_sad;
         w_new_row = r_s3_row;
         w_new_col = r_s3_col;
      end
   end

   // Running minimum update and result publication on the frame's last window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_min      <= C_SAD_INIT;
         r_run_row      <= '0;
         r_run_col      <= '0;
         r_best_sad     <= C_SAD_INIT;
         r_best_row     <= '0;
         r_best_col     <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= r_s3_vld & r_s3_last;
         if (r_s3_vld) begin
            r_run_min <= w_new_min;
            r_run_row <= w_new_row;
            r_run_col <= w_new_col;
            if (r_s3_last) begin
               r_best_sad <= w_new_min;
               r_best_row <= w_new_row;
               r_best_col <= w_new_col;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_template_matcher.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : tb_template_matcher
// Description : Directed self-checking bench for template_matcher. Regions are
//               synthesised pixel by pixel; expected results are hand-derived.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_template_matcher;

   logic                   clk;
   logic                   rst_n;
   logic [15:0][15:0][7:0] template_data;
   logic                   template_load;
   logic [15:0][15:0][7:0] window_data;
   logic                   window_ready;
   logic                   frame_done;
   logic                   receive;
   logic                   busy;
   logic [15:0]            best_sad;
   logic [6:0]             best_row;
   logic [6:0]             best_col;
   logic                   result_valid;

   typedef struct {
      int          cyc;
      logic [15:0] sad;
      logic [6:0]  row;
      logic [6:0]  col;
   } res_t;

   res_t q[$];
   int   cyc      = 0;
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   rcv_err  = 0;
   int   last_cyc = 0;
   int   last_a   = 0;
   int   last_b   = 0;

   template_matcher dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .template_data (template_data),
      .template_load (template_load),
      .window_data   (window_data),
      .window_ready  (window_ready),
      .frame_done    (frame_done),
      .receive       (receive),
      .busy          (busy),
      .best_sad      (best_sad),
      .best_row      (best_row),
      .best_col      (best_col),
      .result_valid  (result_valid)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: value seen during a cycle equals the number of edges so far
   always @(posedge clk) cyc <= cyc + 1;

   // Record every result pulse with its cycle and reported values
   always @(negedge clk) begin
      res_t e;
      #2;
      if (result_valid === 1'b1) begin
         e.cyc = cyc;
         e.sad = best_sad;
         e.row = best_row;
         e.col = best_col;
         q.push_back(e);
      end
   end

   // Template pixel value: 1..241, never zero
   function automatic logic [7:0] tval(input int i, input int j);
      return 8'(1 + i * 15 + j);
   endfunction

   // Region pixel. Mode 0: template block at (10,20) on zero background.
   // Mode 1: block at (40,5). Mode 2: uniform 0x55. Mode 3: uniform 0xFF.
   function automatic logic [7:0] pix(input int mode, input int y, input int x);
      logic [7:0] v;
      v = 8'h00;
      case (mode)
         0: if (y >= 10 && y < 26 && x >= 20 && x < 36) v = tval(y - 10, x - 20);
         1: if (y >= 40 && y < 56 && x >= 5 && x < 21) v = tval(y - 40, x - 5);
         2: v = 8'h55;
         default: v = 8'hFF;
      endcase
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Template kinds: 0 block pattern, 1 uniform 0x55, 2 all zero
   task automatic set_tdata(input int kind);
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            case (kind)
               0:       template_data[i][j] = tval(i, j);
               1:       template_data[i][j] = 8'h55;
               default: template_data[i][j] = 8'h00;
            endcase
         end
      end
   endtask

   task automatic load_template(input int kind);
      @(negedge clk);
      set_tdata(kind);
      template_load = 1'b1;
      @(negedge clk);
      template_load = 1'b0;
   endtask

   task automatic set_window(input int mode, input int r, input int c);
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            window_data[i][j] = pix(mode, r + i, c + j);
         end
      end
   endtask

   // Stream one scan. stop_after >= 0 aborts after that many windows;
   // load_at >= 0 pulses template_load with a zero template at that window.
   task automatic run_frame(input int mode, input int cadence, input int stop_after, input int load_at);
      int idx;
      bit last;
      idx = 0;
      for (int r = 0; r < 65; r++) begin
         for (int c = 0; c < 65; c++) begin
            if (stop_after >= 0 && idx == stop_after) return;
            last = (r == 64 && c == 64);
            @(negedge clk);
            set_window(mode, r, c);
            window_ready = 1'b1;
            frame_done   = last;
            if (load_at >= 0 && idx == load_at) begin
               set_tdata(2);
               template_load = 1'b1;
            end else if (load_at >= 0 && idx == load_at + 1) begin
               set_tdata(0);
               template_load = 1'b0;
            end
            #1;
            if (receive !== 1'b1) rcv_err++;
            if (idx == 10) check("busy_mid_frame", {31'd0, busy}, 32'd1);
            if (last) last_cyc = cyc;
            idx++;
            if (cadence == 2 && !last) begin
               @(negedge clk);
               window_ready = 1'b0;
               frame_done   = 1'b0;
               #1;
               if (receive !== 1'b0) rcv_err++;
            end
         end
      end
   endtask

   // Idle six cycles after the last window, checking the result cycle edges
   task automatic drain(input string tag);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         window_ready = 1'b0;
         frame_done   = 1'b0;
         #1;
         if (receive !== 1'b0) rcv_err++;
         if (k == 4) check({tag, "_busy_at_result"}, {31'd0, busy}, 32'd1);
         if (k == 5) check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
         if (k == 5) check({tag, "_rv_one_cycle"}, {31'd0, result_valid}, 32'd0);
      end
   endtask

   task automatic check_result(input string tag, input int idx, input int exp_cyc,
                               input int sad, input int row, input int col);
      if (q.size() > idx) begin
         check({tag, "_latency"}, q[idx].cyc, exp_cyc);
         check({tag, "_sad"}, {16'd0, q[idx].sad}, sad);
         check({tag, "_row"}, {25'd0, q[idx].row}, row);
         check({tag, "_col"}, {25'd0, q[idx].col}, col);
      end else begin
         check({tag, "_pulse_count"}, q.size(), idx + 1);
      end
   endtask

   // Hard time limit so the run always terminates
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      template_load = 1'b0;
      template_data = '0;
      window_data   = '0;
      window_ready  = 1'b0;
      frame_done    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_receive", {31'd0, receive}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result_valid", {31'd0, result_valid}, 32'd0);
      check("rst_best_sad", {16'd0, best_sad}, 32'hFFFF);
      check("rst_best_row", {25'd0, best_row}, 32'd0);
      check("rst_best_col", {25'd0, best_col}, 32'd0);

      // Exact match at (10,20), one window per cycle
      q.delete(); rcv_err = 0;
      load_template(0);
      run_frame(0, 1, -1, -1);
      drain("exact");
      check_result("exact", 0, last_cyc + 4, 0, 10, 20);
      check("exact_pulses", q.size(), 1);
      check("exact_receive", rcv_err, 0);

      // Same scan at 2-cycle cadence with an ignored mid-frame template load
      q.delete(); rcv_err = 0;
      run_frame(0, 2, -1, 2000);
      drain("cad2_load");
      check_result("cad2_load", 0, last_cyc + 4, 0, 10, 20);
      check("cad2_load_pulses", q.size(), 1);
      check("cad2_load_receive", rcv_err, 0);

      // Uniform tie: earliest position wins
      q.delete(); rcv_err = 0;
      load_template(1);
      run_frame(2, 1, -1, -1);
      drain("tie");
      check_result("tie", 0, last_cyc + 4, 0, 0, 0);

      // Maximum SAD: 256 * 255 without wrap
      q.delete();
      load_template(2);
      run_frame(3, 1, -1, -1);
      drain("maxsad");
      check_result("maxsad", 0, last_cyc + 4, 65280, 0, 0);

      // Reset after 1000 windows aborts the frame
      q.delete();
      load_template(0);
      run_frame(0, 1, 1000, -1);
      @(negedge clk);
      rst_n        = 1'b0;
      window_ready = 1'b0;
      frame_done   = 1'b0;
      #1;
      check("abort_receive", {31'd0, receive}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_result_valid", {31'd0, result_valid}, 32'd0);
      check("abort_best_sad", {16'd0, best_sad}, 32'hFFFF);
      check("abort_best_row", {25'd0, best_row}, 32'd0);
      check("abort_best_col", {25'd0, best_col}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("abort_no_result", q.size(), 0);

      // Full frame after the aborted one
      q.delete(); rcv_err = 0;
      load_template(0);
      run_frame(0, 1, -1, -1);
      drain("post_reset");
      check_result("post_reset", 0, last_cyc + 4, 0, 10, 20);

      // Back-to-back frames with different match positions
      q.delete(); rcv_err = 0;
      run_frame(0, 1, -1, -1);
      last_a = last_cyc;
      run_frame(1, 1, -1, -1);
      last_b = last_cyc;
      drain("b2b");
      check("b2b_pulses", q.size(), 2);
      check_result("b2b_first", 0, last_a + 4, 0, 10, 20);
      check_result("b2b_second", 1, last_b + 4, 0, 40, 5);
      check("b2b_receive", rcv_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
